// File: rtl/instr_sequencer.sv
// instr_sequencer: loadable program store plus program counter that feeds one
// instruction at a time to the downstream multi-cycle control unit. Supports
// free-run and single-step execution, abort, and a sticky error flag.
module instr_sequencer #(
    parameter int DEPTH = 16,
    parameter int AW    = 4,
    parameter int IW    = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load_en,
    input  logic [AW-1:0] load_addr,
    input  logic [IW-1:0] load_data,
    input  logic          start,
    input  logic [AW:0]   len,
    input  logic          step_mode,
    input  logic          step,
    input  logic          abort,
    input  logic          done,
    output logic [IW-1:0] instr,
    output logic          run,
    output logic [AW-1:0] pc,
    output logic          busy,
    output logic          prog_done,
    output logic          err,
    output logic [7:0]    retired
);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        STEP_HOLD
    } state_t;

    localparam logic [AW:0]   DEPTH_L = (AW+1)'(DEPTH);
    localparam logic [AW:0]   ONE_L   = (AW+1)'(1);
    localparam logic [AW-1:0] PC_ONE  = AW'(1);

    state_t        state_q, state_d;
    logic [IW-1:0] mem_q [DEPTH];
    logic [AW:0]   len_q, len_d;
    logic [IW-1:0] instr_d;
    logic [AW-1:0] pc_d;
    logic          pd_d;
    logic          err_d;
    logic [7:0]    ret_d;
    logic          mem_we;
    logic          start_ok;
    logic          last;
    logic [AW-1:0] pc_inc;

    assign start_ok = (len != '0) && (len <= DEPTH_L);
    assign last     = ({1'b0, pc} == (len_q - ONE_L));
    assign pc_inc   = pc + PC_ONE;

    // Next-state and next-output selection; abort overrides every other input.
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        instr_d = instr;
        pc_d    = pc;
        pd_d    = 1'b0;
        err_d   = err;
        ret_d   = retired;
        mem_we  = 1'b0;
        if (abort) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    mem_we = load_en;
                    if (start) begin
                        if (start_ok) begin
                            // mem_q[0] is the pre-write word even if load_addr == 0.
                            len_d   = len;
                            err_d   = 1'b0;
                            ret_d   = '0;
                            pc_d    = '0;
                            instr_d = mem_q[0];
                            state_d = EXEC;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end
                EXEC: begin
                    if (load_en) err_d = 1'b1;
                    if (done) begin
                        ret_d = retired + 8'd1;
                        if (last) begin
                            state_d = IDLE;
                            pd_d    = 1'b1;
                        end else begin
                            pc_d    = pc_inc;
                            instr_d = mem_q[pc_inc];
                            state_d = step_mode ? STEP_HOLD : EXEC;
                        end
                    end
                end
                STEP_HOLD: begin
                    if (load_en) err_d = 1'b1;
                    if (step) state_d = EXEC;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State and registered outputs; run/busy derived from the next state so they
    // line up with the state they describe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            len_q     <= '0;
            instr     <= '0;
            pc        <= '0;
            run       <= 1'b0;
            busy      <= 1'b0;
            prog_done <= 1'b0;
            err       <= 1'b0;
            retired   <= '0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            instr     <= instr_d;
            pc        <= pc_d;
            run       <= (state_d == EXEC);
            busy      <= (state_d != IDLE);
            prog_done <= pd_d;
            err       <= err_d;
            retired   <= ret_d;
        end
    end

    // Program store; cleared by reset, written only while idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (mem_we) begin
            mem_q[load_addr] <= load_data;
        end
    end

endmodule

// File: tb/tb_instr_sequencer.sv
// Scoreboard bench for instr_sequencer: the driver pushes the reference model's
// expected post-edge outputs into a queue, a monitor pops and compares.
module tb_instr_sequencer;
    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int IW    = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          load_en = 1'b0;
    logic [AW-1:0] load_addr = '0;
    logic [IW-1:0] load_data = '0;
    logic          start = 1'b0;
    logic [AW:0]   len = '0;
    logic          step_mode = 1'b0;
    logic          step = 1'b0;
    logic          abort = 1'b0;
    logic          done = 1'b0;
    logic [IW-1:0] instr;
    logic          run;
    logic [AW-1:0] pc;
    logic          busy;
    logic          prog_done;
    logic          err;
    logic [7:0]    retired;

    always #5 clk = ~clk;

    instr_sequencer #(.DEPTH(DEPTH), .AW(AW), .IW(IW)) dut (
        .clk(clk), .rst(rst), .load_en(load_en), .load_addr(load_addr),
        .load_data(load_data), .start(start), .len(len), .step_mode(step_mode),
        .step(step), .abort(abort), .done(done), .instr(instr), .run(run),
        .pc(pc), .busy(busy), .prog_done(prog_done), .err(err), .retired(retired)
    );

    typedef struct packed {
        logic [15:0] instr;
        logic        run;
        logic [3:0]  pc;
        logic        busy;
        logic        pd;
        logic        err;
        logic [7:0]  ret;
    } obs_t;

    typedef struct packed {
        logic        le;
        logic [3:0]  la;
        logic [15:0] ld;
        logic        st;
        logic [4:0]  ln;
        logic        sm;
        logic        stp;
        logic        ab;
        logic        dn;
    } in_t;

    obs_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model: a program is "active" while words remain, "paused" while
    // waiting for a step pulse; m_pos is the word currently presented.
    logic [15:0] m_mem [16];
    bit          m_active, m_paused, m_err, m_pd;
    int          m_len, m_pos, m_ret;
    logic [15:0] m_instr;

    function automatic void model_reset();
        for (int i = 0; i < 16; i++) m_mem[i] = '0;
        m_active = 0; m_paused = 0; m_err = 0; m_pd = 0;
        m_len = 0; m_pos = 0; m_ret = 0; m_instr = '0;
    endfunction

    function automatic void model_step(input in_t s);
        logic [15:0] first;
        first = m_mem[0];
        m_pd  = 0;
        if (s.ab) begin
            m_active = 0;
            m_paused = 0;
        end else if (!m_active) begin
            if (s.le) m_mem[s.la] = s.ld;
            if (s.st) begin
                if (s.ln == 0 || s.ln > 16) m_err = 1;
                else begin
                    m_len = int'(s.ln); m_err = 0; m_ret = 0; m_pos = 0;
                    m_instr = first; m_active = 1; m_paused = 0;
                end
            end
        end else begin
            if (s.le) m_err = 1;
            if (m_paused) begin
                if (s.stp) m_paused = 0;
            end else if (s.dn) begin
                m_ret = (m_ret + 1) % 256;
                if (m_pos == m_len - 1) begin
                    m_active = 0;
                    m_pd = 1;
                end else begin
                    m_pos = m_pos + 1;
                    m_instr = m_mem[m_pos];
                    m_paused = s.sm;
                end
            end
        end
    endfunction

    function automatic obs_t model_obs();
        obs_t o;
        o.instr = m_instr;
        o.run   = m_active && !m_paused;
        o.pc    = 4'(m_pos);
        o.busy  = m_active;
        o.pd    = m_pd;
        o.err   = m_err;
        o.ret   = 8'(m_ret);
        return o;
    endfunction

    task automatic drive(input in_t s);
        @(negedge clk);
        load_en = s.le; load_addr = s.la; load_data = s.ld;
        start = s.st; len = s.ln; step_mode = s.sm;
        step = s.stp; abort = s.ab; done = s.dn;
        model_step(s);
        exp_q.push_back(model_obs());
    endtask

    task automatic idle(input int n);
        in_t s;
        s = '0;
        for (int i = 0; i < n; i++) drive(s);
    endtask

    task automatic load_word(input int a, input logic [15:0] d);
        in_t s;
        s = '0; s.le = 1; s.la = 4'(a); s.ld = d;
        drive(s);
    endtask

    task automatic do_start(input int ln, input bit sm);
        in_t s;
        s = '0; s.st = 1; s.ln = 5'(ln); s.sm = sm;
        drive(s);
    endtask

    // Runs one program; the control unit is modelled as asserting done on every
    // period-th run cycle. Optional abort or illegal load when pc reaches a position.
    task automatic run_prog(input int ln, input bit sm, input int period,
                            input int abort_pos, input int load_pos);
        int  rc, hc, guard;
        bit  loaded;
        in_t s;
        rc = 0; hc = 0; guard = 0; loaded = 0;
        do_start(ln, sm);
        while (m_active && guard < 600) begin
            s = '0;
            s.sm = sm;
            if (!m_paused) begin
                s.dn = ((rc % period) == period - 1);
                if (abort_pos >= 0 && m_pos == abort_pos && (rc % period) == 1) s.ab = 1;
                if (load_pos >= 0 && !loaded && m_pos == load_pos) begin
                    s.le = 1; s.la = 4'd1; s.ld = 16'hFFFF; loaded = 1;
                end
                rc++;
            end else begin
                hc++;
                if (hc >= 5) begin s.stp = 1; hc = 0; end
            end
            drive(s);
            guard++;
        end
        if (guard >= 600) begin
            n_cmp++; n_bad++;
            $display("FAIL run_prog_timeout len=%0d: program still active after %0d cycles, required completion", ln, guard);
        end
    endtask

    task automatic async_reset_check();
        obs_t a;
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        a = {instr, run, pc, busy, prog_done, err, retired};
        n_cmp++;
        if (a != '0) begin
            n_bad++;
            $display("FAIL async_reset: got %h, required all zero", a);
        end
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Monitor: compare DUT outputs 1 time unit after each rising edge.
    always @(posedge clk) begin : monitor
        obs_t e, a;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = {instr, run, pc, busy, prog_done, err, retired};
            n_cmp++;
            if (a !== e) begin
                n_bad++;
                $display("FAIL cycle_check t=%0t: got instr=%h run=%b pc=%0d busy=%b pd=%b err=%b ret=%0d, required instr=%h run=%b pc=%0d busy=%b pd=%b err=%b ret=%0d",
                         $time, a.instr, a.run, a.pc, a.busy, a.pd, a.err, a.ret,
                         e.instr, e.run, e.pc, e.busy, e.pd, e.err, e.ret);
            end
        end
    end

    initial begin
        in_t s;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        idle(2);

        load_word(0, 16'h2A18);
        load_word(1, 16'h4C20);
        load_word(2, 16'h6E2C);
        idle(1);
        run_prog(3, 0, 4, -1, -1);
        idle(2);

        do_start(0, 0);
        idle(1);
        do_start(17, 0);
        idle(1);
        run_prog(1, 0, 4, -1, -1);
        idle(2);

        run_prog(3, 1, 4, -1, -1);
        idle(2);

        run_prog(3, 0, 4, -1, 1);
        idle(2);

        run_prog(3, 0, 4, 1, -1);
        idle(2);
        run_prog(3, 0, 4, -1, -1);
        idle(2);

        for (int i = 0; i < 16; i++) load_word(i, 16'($urandom));
        run_prog(16, 0, 1, -1, -1);
        idle(2);

        do_start(3, 0);
        idle(3);
        async_reset_check();
        run_prog(1, 0, 4, -1, -1);
        idle(2);

        for (int i = 0; i < 1500; i++) begin
            s = '0;
            s.le  = ($urandom_range(0, 9) == 0);
            s.la  = 4'($urandom);
            s.ld  = 16'($urandom);
            s.st  = ($urandom_range(0, 19) == 0);
            s.ln  = 5'($urandom_range(0, 17));
            s.sm  = ($urandom_range(0, 2) == 0);
            s.stp = ($urandom_range(0, 4) == 0);
            s.ab  = ($urandom_range(0, 99) == 0);
            s.dn  = ($urandom_range(0, 2) == 0);
            drive(s);
        end
        idle(3);
        @(posedge clk);
        #3;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
